// File: rtl/snake_dir_ctrl.sv
// -----------------------------------------------------------------------------
// snake_dir_ctrl
//
// Turns the keyboard decoder's key-held levels into snake movement control.
// The key levels are synchronised into the clk domain and reduced to one-cycle
// press events. Illegal turns are filtered and up to two pending turns are
// buffered. A free-running tick counter produces the movement step, and each
// step applies one buffered turn.
//
// Parameters:
//   TICK_DIV   - clock cycles per movement step (>= 2)
//
// Ports:
//   clk        - system clock
//   rst_n      - asynchronous active-low reset
//   up/down/left/right - direction key levels (asynchronous to clk)
//   reset_key  - game reset key level (asynchronous to clk)
//   dir        - current direction: 00 up, 01 down, 10 left, 11 right
//   step       - one-cycle pulse per movement tick
//   game_reset - one-cycle pulse per reset-key press
//   q_count    - number of pending turns (0..2)
// -----------------------------------------------------------------------------
module snake_dir_ctrl #(
    parameter int TICK_DIV = 25_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       up,
    input  logic       down,
    input  logic       left,
    input  logic       right,
    input  logic       reset_key,
    output logic [1:0] dir,
    output logic       step,
    output logic       game_reset,
    output logic [1:0] q_count
);

    localparam int             CW       = $clog2(TICK_DIV);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TICK_DIV - 1);

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    // Key vector bit positions.
    localparam int K_RESET = 4;
    localparam int K_UP    = 3;
    localparam int K_DOWN  = 2;
    localparam int K_LEFT  = 1;
    localparam int K_RIGHT = 0;

    logic [4:0]    key_raw;
    logic [4:0]    sync1;
    logic [4:0]    sync2;
    logic [4:0]    hist;
    logic [4:0]    press;

    logic [CW-1:0] cnt;
    logic [1:0]    q0;          // queue head
    logic [1:0]    q1;          // second entry, valid when q_count == 2

    logic          new_valid;
    logic [1:0]    new_dir;
    logic [1:0]    ref_dir;
    logic          accept;
    logic          wrap;
    logic          pop;

    assign key_raw = {reset_key, up, down, left, right};

    // Rising edge of the synchronised level; releases produce nothing.
    assign press = sync2 & ~hist;

    // NOTE: every signal driven here gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        new_valid = 1'b1;
        new_dir   = DIR_UP;
        if (press[K_UP]) begin
            new_dir = DIR_UP;
        end else if (press[K_DOWN]) begin
            new_dir = DIR_DOWN;
        end else if (press[K_LEFT]) begin
            new_dir = DIR_LEFT;
        end else if (press[K_RIGHT]) begin
            new_dir = DIR_RIGHT;
        end else begin
            new_valid = 1'b0;
        end

        // A new turn is judged against the last direction the snake will have
        // taken, i.e. the queue tail if anything is pending.
        case (q_count)
            2'd0:    ref_dir = dir;
            2'd1:    ref_dir = q0;
            default: ref_dir = q1;
        endcase

        // Same direction or its opposite share the axis bit (bit 1), so one
        // compare rejects both. The full check uses the pre-pop count.
        accept = new_valid && (q_count != 2'd2) && (new_dir[1] != ref_dir[1]);

        wrap = (cnt == CNT_LAST);
        pop  = wrap && (q_count != 2'd0);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1      <= '0;
            sync2      <= '0;
            hist       <= '0;
            cnt        <= '0;
            step       <= 1'b0;
            game_reset <= 1'b0;
            dir        <= DIR_RIGHT;
            q_count    <= 2'd0;
            // NOTE: the queue storage is reset too; it is two small registers,
            // and a defined value keeps the tail mux free of X in simulation.
            q0         <= DIR_UP;
            q1         <= DIR_UP;
        end else begin
            sync1 <= key_raw;
            sync2 <= sync1;
            hist  <= sync2;

            if (press[K_RESET]) begin
                // Reset key overrides everything else seen on this edge.
                game_reset <= 1'b1;
                cnt        <= '0;
                step       <= 1'b0;
                dir        <= DIR_RIGHT;
                q_count    <= 2'd0;
            end else begin
                game_reset <= 1'b0;
                cnt        <= wrap ? '0 : cnt + CW'(1);
                step       <= wrap;

                if (pop) begin
                    dir <= q0;
                end

                case ({pop, accept})
                    2'b11: begin
                        // Count stays the same: shift and append.
                        if (q_count == 2'd2) begin
                            q0 <= q1;
                            q1 <= new_dir;
                        end else begin
                            q0 <= new_dir;
                        end
                    end
                    2'b10: begin
                        q0      <= q1;
                        q_count <= q_count - 2'd1;
                    end
                    2'b01: begin
                        if (q_count == 2'd0) begin
                            q0 <= new_dir;
                        end else begin
                            q1 <= new_dir;
                        end
                        q_count <= q_count + 2'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
